// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and sizes for the SDRAM port arbiter
package sdram_arb_pkg;

   localparam int MAX_PORTS  = 8;
   localparam int PORT_IDX_W = $clog2(MAX_PORTS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// rtl/sdram_arb_rr_pick.sv - round-robin pick over ports 1..NUM_PORTS-1
// Bit 0 (fixed-priority port) is never picked here.
module sdram_arb_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3
) (
   input  logic [NUM_PORTS-1:0]  req,
   input  logic [PORT_IDX_W-1:0] last,
   output logic [NUM_PORTS-1:0]  grant,
   output logic                  valid
);

   logic unused_req0;
   assign unused_req0 = req[0];

   // Two passes: ports above the last grant first, then wrap to port 1.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int p = 1; p < NUM_PORTS; p++) begin
         if (!valid && req[p] && (p > int'(last))) begin
            grant[p] = 1'b1;
            valid    = 1'b1;
         end
      end
      for (int p = 1; p < NUM_PORTS; p++) begin
         if (!valid && req[p] && (p <= int'(last))) begin
            grant[p] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - multi-port arbiter for the SDRAM controller request port
// SDRAM_ARB_STARVE_GUARD_EN enables the port-0 burst limit (MAX_BURST).
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 8
) (
   input  logic                              clk,
   input  logic                              reset_i,
   input  logic [NUM_PORTS-1:0]              req_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wmask_i,
   output logic [NUM_PORTS-1:0]              ack_o,
   output logic [DATA_WIDTH-1:0]             rdata_o,
   output logic                              ctrl_req_o,
   output logic                              ctrl_we_o,
   output logic [ADDR_WIDTH-1:0]             ctrl_addr_o,
   output logic [DATA_WIDTH-1:0]             ctrl_wdata_o,
   output logic [DATA_WIDTH/8-1:0]           ctrl_wmask_o,
   input  logic                              ctrl_ack_i,
   input  logic [DATA_WIDTH-1:0]             ctrl_rdata_i,
   output logic                              busy_o
);

   localparam int MW = DATA_WIDTH / 8;

   arb_state_t state, state_nxt;
   logic       load, done;

   logic [PORT_IDX_W-1:0] grant_idx, rr_last, win_idx;
   logic [NUM_PORTS-1:0]  rr_grant, win_oh;
   logic                  rr_valid, excl_p0, p0_win;

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [MW-1:0]         sel_wmask;

   sdram_arb_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
      .req   (req_i),
      .last  (rr_last),
      .grant (rr_grant),
      .valid (rr_valid)
   );

`ifdef SDRAM_ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   assign excl_p0 = (starve_cnt == 4'(MAX_BURST)) && rr_valid;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         starve_cnt <= 4'd0;
      end else if (load) begin
         if (!p0_win || !rr_valid)
            starve_cnt <= 4'd0;
         else if (starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_BURST != 0);
   assign excl_p0    = 1'b0;
`endif

   assign p0_win = req_i[0] && !excl_p0;
   assign win_oh = p0_win ? NUM_PORTS'(1) : rr_grant;
   assign busy_o = (state != IDLE);

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wmask = '0;
      win_idx   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (win_oh[p]) begin
            sel_we    = we_i[p];
            sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            sel_wmask = wmask_i[p*MW +: MW];
            win_idx   = PORT_IDX_W'(p);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (|req_i) begin
            load      = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (ctrl_ack_i) begin
            done      = 1'b1;
            state_nxt = ACK;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         ctrl_req_o   <= 1'b0;
         ctrl_we_o    <= 1'b0;
         ctrl_addr_o  <= '0;
         ctrl_wdata_o <= '0;
         ctrl_wmask_o <= '0;
         ack_o        <= '0;
         rdata_o      <= '0;
         grant_idx    <= '0;
         rr_last      <= PORT_IDX_W'(NUM_PORTS - 1);
      end else begin
         ack_o <= '0;
         if (load) begin
            ctrl_req_o   <= 1'b1;
            ctrl_we_o    <= sel_we;
            ctrl_addr_o  <= sel_addr;
            ctrl_wdata_o <= sel_wdata;
            ctrl_wmask_o <= sel_wmask;
            grant_idx    <= win_idx;
            // Only low-priority grants advance the round-robin pointer.
            if (win_idx != '0) rr_last <= win_idx;
         end
         if (done) begin
            ctrl_req_o <= 1'b0;
            rdata_o    <= ctrl_rdata_i;
            ack_o      <= NUM_PORTS'(1) << grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

   localparam int NP = 3;
   localparam int AW = 24;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic             clk = 1'b0;
   logic             reset_i;
   logic [NP-1:0]    req_i, we_i;
   logic [NP*AW-1:0] addr_i;
   logic [NP*DW-1:0] wdata_i;
   logic [NP*MW-1:0] wmask_i;
   logic [NP-1:0]    ack_o;
   logic [DW-1:0]    rdata_o;
   logic             ctrl_req_o, ctrl_we_o;
   logic [AW-1:0]    ctrl_addr_o;
   logic [DW-1:0]    ctrl_wdata_o;
   logic [MW-1:0]    ctrl_wmask_o;
   logic             ctrl_ack_i;
   logic [DW-1:0]    ctrl_rdata_i;
   logic             busy_o;

   int checks = 0;
   int errors = 0;

   logic [NP-1:0] ack;
   logic [NP-1:0] exp_burst [6];
   logic [NP-1:0] exp_mix [3];
   logic [NP-1:0] exp_alt [4];
   int            gap;
   int            n_ack, n_req;

   sdram_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_BURST (2)
   ) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .req_i        (req_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .wmask_i      (wmask_i),
      .ack_o        (ack_o),
      .rdata_o      (rdata_o),
      .ctrl_req_o   (ctrl_req_o),
      .ctrl_we_o    (ctrl_we_o),
      .ctrl_addr_o  (ctrl_addr_o),
      .ctrl_wdata_o (ctrl_wdata_o),
      .ctrl_wmask_o (ctrl_wmask_o),
      .ctrl_ack_i   (ctrl_ack_i),
      .ctrl_rdata_i (ctrl_rdata_i),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
      we_i[p]             = we;
      addr_i[p*AW +: AW]  = a;
      wdata_i[p*DW +: DW] = d;
      wmask_i[p*MW +: MW] = m;
   endtask

   task automatic wait_req(input string tag, output int n);
      n = 0;
      while (ctrl_req_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(ctrl_req_o), 64'(1'b1));
   endtask

   task automatic serve(input int lat, input logic [DW-1:0] rd, output logic [NP-1:0] ack_seen);
      logic [60:0] snap;
      snap = {ctrl_we_o, ctrl_addr_o, ctrl_wdata_o, ctrl_wmask_o};
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check("busy_hold", 64'({ctrl_req_o, busy_o, ack_o}), 64'({1'b1, 1'b1, 3'b000}));
         check("field_hold", 64'({ctrl_we_o, ctrl_addr_o, ctrl_wdata_o, ctrl_wmask_o}), 64'(snap));
      end
      ctrl_rdata_i = rd;
      ctrl_ack_i   = 1'b1;
      @(negedge clk);
      ctrl_ack_i   = 1'b0;
      ctrl_rdata_i = 32'h0BAD_F00D;
      ack_seen = ack_o;
      check("ack_rdata", 64'(rdata_o), 64'(rd));
      check("ack_req_clr", 64'({ctrl_req_o, busy_o}), 64'(2'b01));
   endtask

   initial begin
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      exp_burst = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b010};
      exp_mix   = '{3'b001, 3'b001, 3'b100};
`else
      exp_burst = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      exp_mix   = '{3'b001, 3'b001, 3'b001};
`endif
      exp_alt = '{3'b010, 3'b100, 3'b010, 3'b100};

      reset_i = 1'b1;
      req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; wmask_i = '0;
      ctrl_ack_i = 1'b0; ctrl_rdata_i = '0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", 64'({ctrl_req_o, ctrl_we_o, busy_o, ack_o}), 64'(0));
      check("rst_fields", 64'({ctrl_addr_o, ctrl_wdata_o, ctrl_wmask_o}), 64'(0));
      check("rst_rdata", 64'(rdata_o), 64'(0));
      reset_i = 1'b0;

      ctrl_ack_i = 1'b1; ctrl_rdata_i = 32'h1234_5678;
      @(negedge clk);
      ctrl_ack_i = 1'b0;
      check("stray_ack", 64'({ack_o, busy_o, ctrl_req_o}), 64'(0));
      check("stray_rdata", 64'(rdata_o), 64'(0));
      @(negedge clk);

      // Single read on port 1
      set_port(1, 1'b0, 24'h000123, 32'h0, 4'h0);
      req_i = 3'b010;
      wait_req("p1_req", gap);
      check("p1_fields", 64'({ctrl_we_o, ctrl_addr_o}), 64'({1'b0, 24'h000123}));
      check("p1_busy", 64'(busy_o), 64'(1'b1));
      serve(4, 32'hDEAD_BEEF, ack);
      check("p1_ack", 64'(ack), 64'(3'b010));
      req_i = 3'b000;
      @(negedge clk);
      check("p1_ack_pulse", 64'({ack_o, ctrl_req_o, busy_o}), 64'(0));
      check("p1_rdata_hold", 64'(rdata_o), 64'(32'hDEAD_BEEF));

      // Write on port 2
      set_port(2, 1'b1, 24'h0000AA, 32'hA5A5_A5A5, 4'b0011);
      req_i = 3'b100;
      wait_req("p2_req", gap);
      check("p2_fields", 64'({ctrl_we_o, ctrl_wdata_o, ctrl_wmask_o}), 64'({1'b1, 32'hA5A5_A5A5, 4'b0011}));
      check("p2_addr", 64'(ctrl_addr_o), 64'(24'h0000AA));
      serve(3, 32'h1111_1111, ack);
      check("p2_ack", 64'(ack), 64'(3'b100));
      req_i = 3'b000;
      @(negedge clk);

      // Port 0 against port 1, then against both low-priority ports
      set_port(0, 1'b0, 24'h000100, 32'h0, 4'h0);
      set_port(1, 1'b0, 24'h000101, 32'h0, 4'h0);
      set_port(2, 1'b0, 24'h000102, 32'h0, 4'h0);
      req_i = 3'b011;
      for (int i = 0; i < 6; i++) begin
         wait_req("burst_req", gap);
         if (i > 0) check("b2b_gap", 64'(gap), 64'(2));
         serve(0, 32'h2000_0000 + DW'(i), ack);
         check("burst_order", 64'(ack), 64'(exp_burst[i]));
      end
      req_i = 3'b111;
      for (int i = 0; i < 3; i++) begin
         wait_req("mix_req", gap);
         serve(0, 32'h3000_0000 + DW'(i), ack);
         check("mix_order", 64'(ack), 64'(exp_mix[i]));
      end
      req_i = 3'b110;
      for (int i = 0; i < 4; i++) begin
         wait_req("alt_req", gap);
         serve(1, 32'h4000_0000 + DW'(i), ack);
         check("alt_order", 64'(ack), 64'(exp_alt[i]));
      end
      req_i = 3'b000;
      @(negedge clk);
      check("alt_idle", 64'({busy_o, ctrl_req_o, ack_o}), 64'(0));

      // Reset while BUSY
      req_i = 3'b001;
      wait_req("rst_busy_req", gap);
      #2 reset_i = 1'b1;
      #1 check("rst_async", 64'({ctrl_req_o, busy_o}), 64'(0));
      ctrl_ack_i = 1'b1;
      @(negedge clk);
      check("rst_no_ack", 64'(ack_o), 64'(0));
      reset_i = 1'b0; ctrl_ack_i = 1'b0; req_i = 3'b000;
      @(negedge clk);
      check("rst_after", 64'({ack_o, busy_o, ctrl_req_o}), 64'(0));
      set_port(1, 1'b0, 24'h000456, 32'h0, 4'h0);
      req_i = 3'b010;
      wait_req("post_rst_req", gap);
      check("post_rst_addr", 64'(ctrl_addr_o), 64'(24'h000456));
      serve(1, 32'hCAFE_F00D, ack);
      check("post_rst_ack", 64'(ack), 64'(3'b010));
      req_i = 3'b000;
      @(negedge clk);

      // Request held through ACK, dropped at the edge ending it
      set_port(2, 1'b0, 24'h000789, 32'h0, 4'h0);
      req_i = 3'b100;
      wait_req("hold_req", gap);
      serve(2, 32'h55AA_55AA, ack);
      check("hold_ack", 64'(ack), 64'(3'b100));
      @(posedge clk);
      #1 req_i = 3'b000;
      n_ack = 0; n_req = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_o != '0) n_ack++;
         if (ctrl_req_o) n_req++;
      end
      check("hold_no_dup_ack", 64'(n_ack), 64'(0));
      check("hold_no_dup_req", 64'(n_req), 64'(0));
      check("hold_rdata", 64'(rdata_o), 64'(32'h55AA_55AA));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
